// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU scheduler: opcode codes, FSM state encoding and
// the pass-select values that steer the ALU input mux.
package alu_sched_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_FIX,
    ST_RESP
  } alu_sched_state_t;

  localparam logic [1:0] PASS_LO  = 2'd0;
  localparam logic [1:0] PASS_HI  = 2'd1;
  localparam logic [1:0] PASS_FIX = 2'd2;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

  function automatic logic is_shift(input logic [2:0] op);
    return (op == ALU_SHL) || (op == ALU_SHR);
  endfunction

endpackage

// File: rtl/alu_sched_alu.sv
// 16-bit combinational ALU; carry is the add carry-out or the subtract borrow,
// zero flags an all-zero result. No latency, no flow control.
module alu
  import alu_sched_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y,
  output logic        carry,
  output logic        zero
);

  logic [16:0] sum;

  always_comb begin
    sum   = 17'd0;
    y     = 16'd0;
    carry = 1'b0;
    case (op)
      ALU_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        y     = sum[15:0];
        carry = sum[16];
      end
      ALU_SUB: begin
        // Bit 16 of the 17-bit difference is set exactly when a < b.
        sum   = {1'b0, a} - {1'b0, b};
        y     = sum[15:0];
        carry = sum[16];
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOT: y = ~a;
      ALU_SHL: y = a << b[3:0];
      ALU_SHR: y = a >> b[3:0];
      default: y = 16'd0;
    endcase
  end

  assign zero = (y == 16'd0);

endmodule

// File: rtl/alu_sched.sv
// Round-robin arbiter sharing one 16-bit ALU; wide ops run as LO/HI(/FIX) passes.
// Latency grant->rsp_valid 2/3/4 cycles; holds the response until rsp_ready, no grants meanwhile.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [NREQ-1:0]      req_wide,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_lo,
  output logic [15:0]          rsp_hi,
  output logic                 rsp_carry,
  output logic                 rsp_zero
);

  alu_sched_state_t state;
  logic [ID_W-1:0]  last;
  logic [2:0]       op_q;
  logic             wide_q;
  logic [31:0]      a_q, b_q;
  logic [15:0]      lo_q, hi_q;
  logic             lo_c, hi_c;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                off, w_int;
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;

  // Rotate so that bit 0 is requester last+1, then pick the lowest set bit.
  always_comb begin
    dbl       = {req_valid, req_valid} >> (int'(last) + 1);
    rot       = dbl[NREQ-1:0];
    off       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    w_int     = int'(last) + 1 + off;
    if (w_int >= NREQ) w_int = w_int - NREQ;
    grant_id  = ID_W'(w_int);
    grant_any = |req_valid;
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && !rst && grant_any) req_ready[grant_id] = 1'b1;
  end

  logic [2:0]  sel_op;
  logic        sel_wide;
  logic [31:0] sel_a, sel_b;

  always_comb begin
    sel_op   = 3'd0;
    sel_wide = 1'b0;
    sel_a    = 32'd0;
    sel_b    = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_op   = req_op[3*i +: 3];
        sel_wide = req_wide[i];
        sel_a    = req_a[32*i +: 32];
        sel_b    = req_b[32*i +: 32];
      end
    end
  end

  logic [1:0]  pass_sel;
  logic [15:0] alu_a, alu_b, alu_y;
  logic        alu_c, alu_z;

  always_comb begin
    pass_sel = PASS_LO;
    if (state == ST_HI)       pass_sel = PASS_HI;
    else if (state == ST_FIX) pass_sel = PASS_FIX;
    alu_a = a_q[15:0];
    alu_b = b_q[15:0];
    case (pass_sel)
      PASS_HI: begin
        alu_a = a_q[31:16];
        alu_b = b_q[31:16];
      end
      PASS_FIX: begin
        alu_a = hi_q;
        alu_b = 16'd1;
      end
      default: ;
    endcase
  end

  alu u_alu (
    .op    (op_q),
    .a     (alu_a),
    .b     (alu_b),
    .y     (alu_y),
    .carry (alu_c),
    .zero  (alu_z)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      last      <= ID_W'(NREQ - 1);
      op_q      <= 3'd0;
      wide_q    <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      lo_q      <= 16'd0;
      hi_q      <= 16'd0;
      lo_c      <= 1'b0;
      hi_c      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_lo    <= 16'd0;
      rsp_hi    <= 16'd0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            op_q   <= sel_op;
            wide_q <= sel_wide & ~is_shift(sel_op);
            a_q    <= sel_a;
            b_q    <= sel_b;
            rsp_id <= grant_id;
            last   <= grant_id;
            state  <= ST_LO;
          end
        end
        ST_LO: begin
          lo_q <= alu_y;
          if (op_q == ALU_ADD)      lo_c <= alu_c;
          else if (op_q == ALU_SUB) lo_c <= (a_q[15:0] < b_q[15:0]);
          else                      lo_c <= 1'b0;
          if (wide_q) begin
            state <= ST_HI;
          end else begin
            rsp_lo    <= alu_y;
            rsp_hi    <= 16'd0;
            rsp_carry <= alu_c;
            rsp_zero  <= alu_z;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_HI: begin
          hi_q <= alu_y;
          hi_c <= alu_c;
          if (is_arith(op_q) && lo_c) begin
            state <= ST_FIX;
          end else begin
            rsp_lo    <= lo_q;
            rsp_hi    <= alu_y;
            rsp_carry <= alu_c;
            rsp_zero  <= (alu_y == 16'd0) && (lo_q == 16'd0);
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_FIX: begin
          // Carry/borrow can come from the HI pass or the +-1 fix, never both.
          rsp_lo    <= lo_q;
          rsp_hi    <= alu_y;
          rsp_carry <= hi_c | alu_c;
          rsp_zero  <= (alu_y == 16'd0) && (lo_q == 16'd0);
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: vector table on requester 0 plus arbitration,
// backpressure and mid-operation reset sequences.
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_wide;
  logic [5:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [0:0]  rsp_id;
  logic [15:0] rsp_lo, rsp_hi;
  logic        rsp_carry, rsp_zero;

  int n_pass  = 0;
  int n_total = 0;

  alu_sched #(.NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_wide  (req_wide),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_lo    (rsp_lo),
    .rsp_hi    (rsp_hi),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        wide;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        c;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_req(input int r, input logic [2:0] op, input logic wide,
                         input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      req_op[2:0] = op; req_wide[0] = wide; req_a[31:0] = a; req_b[31:0] = b;
    end else begin
      req_op[5:3] = op; req_wide[1] = wide; req_a[63:32] = a; req_b[63:32] = b;
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 30);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int lat;
    @(negedge clk);
    set_req(0, v.op, v.wide, v.a, v.b);
    req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("v%0d_grant", idx), req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rsp(lat);
    chk($sformatf("v%0d_lat", idx), lat, v.lat);
    chk($sformatf("v%0d_lo", idx), rsp_lo, v.lo);
    chk($sformatf("v%0d_hi", idx), rsp_hi, v.hi);
    chk($sformatf("v%0d_carry", idx), rsp_carry, v.c);
    chk($sformatf("v%0d_zero", idx), rsp_zero, v.z);
    chk($sformatf("v%0d_id", idx), rsp_id, 0);
    handshake();
  endtask

  initial begin
    int lat;
    int got;
    int n;

    rst = 1'b1; rsp_ready = 1'b0;
    req_op = '0; req_wide = '0; req_a = '0; req_b = '0;
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_lo", rsp_lo, 0);
    chk("rst_rsp_hi", rsp_hi, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_rsp_id", rsp_id, 0);
    req_valid = 2'b00;
    rst = 1'b0;

    //          op       wide  a             b             lo        hi        c     z     lat
    vecs[0]  = '{ALU_ADD, 1'b0, 32'h0000FFFF, 32'h00000001, 16'h0000, 16'h0000, 1'b1, 1'b1, 2};
    vecs[1]  = '{ALU_ADD, 1'b1, 32'h0001FFFF, 32'h00000001, 16'h0000, 16'h0002, 1'b0, 1'b0, 4};
    vecs[2]  = '{ALU_SUB, 1'b1, 32'h00010000, 32'h00000001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 4};
    vecs[3]  = '{ALU_SUB, 1'b1, 32'h00000000, 32'h00000001, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 4};
    vecs[4]  = '{ALU_ADD, 1'b1, 32'h12345678, 32'h11111111, 16'h6789, 16'h2345, 1'b0, 1'b0, 3};
    vecs[5]  = '{ALU_ADD, 1'b1, 32'hFFFF0000, 32'h00010000, 16'h0000, 16'h0000, 1'b1, 1'b1, 3};
    vecs[6]  = '{ALU_AND, 1'b1, 32'hF0F0FFFF, 32'h0FF000FF, 16'h00FF, 16'h00F0, 1'b0, 1'b0, 3};
    vecs[7]  = '{ALU_XOR, 1'b0, 32'h0000AAAA, 32'h0000AAAA, 16'h0000, 16'h0000, 1'b0, 1'b1, 2};
    vecs[8]  = '{ALU_SHL, 1'b1, 32'h00010003, 32'h00000004, 16'h0030, 16'h0000, 1'b0, 1'b0, 2};
    vecs[9]  = '{ALU_SHR, 1'b0, 32'h00008000, 32'h0000000F, 16'h0001, 16'h0000, 1'b0, 1'b0, 2};
    vecs[10] = '{ALU_NOT, 1'b1, 32'hFFFF0000, 32'h00000000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 3};
    vecs[11] = '{ALU_SUB, 1'b0, 32'h00000003, 32'h00000005, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 2};
    vecs[12] = '{ALU_OR,  1'b1, 32'h00000000, 32'h00000000, 16'h0000, 16'h0000, 1'b0, 1'b1, 3};
    vecs[13] = '{ALU_SUB, 1'b1, 32'h00000005, 32'h00000005, 16'h0000, 16'h0000, 1'b0, 1'b1, 3};

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Reset puts 'last' back to 1, so requester 0 must win first again.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_req(0, ALU_XOR, 1'b0, 32'h1, 32'h2);
    set_req(1, ALU_XOR, 1'b0, 32'h4, 32'h1);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    got = 0; n = 0;
    while (got < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        chk($sformatf("alt%0d_id", got), rsp_id, got % 2);
        chk($sformatf("alt%0d_lo", got), rsp_lo, (got % 2 == 1) ? 32'h5 : 32'h3);
        got++;
        if (got == 4) req_valid = 2'b00;
      end
    end
    req_valid = 2'b00;
    chk("alt_count", got, 4);
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Backpressure: response held 5 extra cycles while req1 waits.
    @(negedge clk);
    set_req(0, ALU_ADD, 1'b0, 32'h1, 32'h1);
    set_req(1, ALU_XOR, 1'b0, 32'hF, 32'h3);
    req_valid = 2'b11;
    #1 chk("stall_grant0", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rsp(lat);
    chk("stall_lat", lat, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", k), rsp_valid, 1);
      chk($sformatf("stall%0d_lo", k), rsp_lo, 32'h2);
      chk($sformatf("stall%0d_id", k), rsp_id, 0);
      chk($sformatf("stall%0d_req_ready", k), req_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("stall_next_grant", req_ready, 2'b10);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_rsp(lat);
    chk("stall_req1_id", rsp_id, 1);
    chk("stall_req1_lo", rsp_lo, 32'hC);
    handshake();

    // Reset while a wide ADD sits in the HI pass.
    @(negedge clk);
    set_req(0, ALU_ADD, 1'b1, 32'h0001FFFF, 32'h1);
    req_valid = 2'b01;
    #1 chk("mid_grant", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(posedge clk);
    #1;
    set_req(0, ALU_ADD, 1'b0, 32'h2, 32'h3);
    set_req(1, ALU_ADD, 1'b0, 32'h7, 32'h7);
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_lo", rsp_lo, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_req_ready", req_ready, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_post_grant", req_ready, 2'b01);
    chk("mid_post_valid", rsp_valid, 0);
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_rsp(lat);
    chk("mid_post_lat", lat, 2);
    chk("mid_post_id", rsp_id, 0);
    chk("mid_post_lo", rsp_lo, 32'h5);
    chk("mid_post_hi", rsp_hi, 0);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares the single 16-bit `alu` datapath between `NREQ` requesters and sequences 32-bit ("wide") operations as multiple 16-bit ALU passes. It sits between the execute/address-generation requesters and the `alu` instance. It grants one request at a time, runs the required passes and returns a registered result with flags over a valid/ready response port.

## Interface
- `NREQ`, default 2: number of requesters, minimum 2.
- `ID_W`, default `$clog2(NREQ)`: width of the requester index.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester grant; one-hot or zero.
- `req_op`  in  3*NREQ  ALU opcode per requester, encoded as the `ALU_*` codes.
- `req_wide`  in  NREQ  1 = 32-bit operation.
- `req_a`, `req_b`  in  32*NREQ  operands; only bits [15:0] are used when narrow.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  ID_W  index of the requester that issued the request.
- `rsp_lo`, `rsp_hi`  out  16 each  result low and high halves; `rsp_hi` = 0 for narrow.
- `rsp_carry`, `rsp_zero`  out  1 each  result flags.

## Operation
- FSM states: IDLE, LO, HI, FIX, RESP.
- **IDLE:**
  - The round-robin search starts at `last+1` and wraps modulo NREQ.
  - The first requester found with `req_valid` is the winner `w`. `req_ready[w]`=1 combinationally in this cycle.
  - Operands, op, wide and id are captured at the clock edge, `last` ← w, and the FSM moves to LO.
  - `req_ready` is 0 in every state other than IDLE.
- **LO:**
  - ALU inputs are `a[15:0]` and `b[15:0]`; the result and carry are registered.
  - For ADD/SUB, `lo_c` is registered: for ADD it is the ALU carry; for SUB it is the unsigned borrow `a[15:0] < b[15:0]`, computed locally.
  - Next state: RESP if narrow, otherwise HI.
- **HI:**
  - ALU inputs are `a[31:16]` and `b[31:16]` (NOT uses a only).
  - Next state: FIX if op is ADD/SUB and `lo_c`=1, otherwise RESP.
- **FIX:** ALU computes hi_result ± 1 (ADD uses `ALU_ADD`, SUB uses `ALU_SUB`, with arg_b = 1). Next state: RESP.
- **RESP:** `rsp_valid`=1 and all `rsp_*` outputs are held stable until `rsp_ready`, then the FSM moves to IDLE.
- Wide SHL/SHR: `req_wide` is ignored and the operation executes as narrow (`rsp_hi`=0).
- Narrow flags: ALU `carry` and `zero` are passed through unchanged.
- Wide flags:
  - `rsp_zero` = ({hi,lo} == 0).
  - ADD: `rsp_carry` = bit 32 of the exact `a+b`.
  - SUB: `rsp_carry` = unsigned `a < b` (32-bit).
  - AND/OR/XOR/NOT: `rsp_carry` = 0.
- Requester rules:
  - A requester holds `req_valid` and its operands stable until granted.
  - Dropping `req_valid` before the grant is allowed; the dropped request is never granted.

## Timing
- Reset values:
  - FSM state IDLE and `last` = NREQ-1, so requester 0 wins first.
  - `rsp_valid`=0, `rsp_lo`=0, `rsp_hi`=0, `rsp_carry`=0, `rsp_zero`=0, `rsp_id`=0.
  - `req_ready`=0 while `rst` is asserted.
- Latency from the grant edge to `rsp_valid`:
  - narrow: 2 cycles;
  - wide without fix: 3 cycles;
  - wide with fix: 4 cycles.
- Throughput: the next grant can occur at the earliest in the cycle after the response handshake. There is no overlap between operations.
- The `rsp_valid`/`rsp_ready` handshake and a new `req_valid` in the same cycle: the FSM returns to IDLE and arbitration happens in the following cycle.
- Reset mid-operation: the in-flight transaction is discarded, with no response and no grant.
- `rsp_ready` held low: the FSM stays in RESP indefinitely and every requester is stalled.

## Structure
- Shared package:
  - FSM state typedef `alu_sched_state_t`.
  - Pass-select constants.
  - Existing `ALU_*` opcode defines from `constants.sv`.
- Single sub-module: `alu` (existing), instantiated once. ALU input muxing is selected by FSM state.
- Arbitration is inline (a rotate-and-priority-encode); it is not a separate module.

## Test plan
- Narrow ADD, req0, a=0xFFFF, b=0x0001 → grant at cycle 0, `rsp_valid` at cycle 2, lo=0x0000, carry=1, zero=1, id=0.
- Wide ADD, a=0x0001FFFF, b=0x00000001 → takes the FIX path, `rsp_valid` at cycle 4, {hi,lo}=0x00020000, carry=0, zero=0.
- Wide SUB, a=0x00010000, b=0x00000001 → {hi,lo}=0x0000FFFF, carry=0. Wide SUB 0 − 1 → 0xFFFFFFFF, carry=1.
- Both requesters continuously valid, narrow XOR → grants alternate 0,1,0,1; `rsp_id` sequence matches.
- `rsp_ready` held low for 5 cycles → outputs stable, `req_ready` stays 0, and a pending req1 is granted the cycle after the handshake.
- `rst` asserted in the HI state of a wide op → outputs take reset values immediately; after release, req0 is granted first and no stale response appears.
